// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing for the five-stage core: stage enables/clears,
// debug execution-mode FSM and saturating performance counters.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_req,
    input  logic             branch_taken,
    input  logic             halt_instr_wb,
    input  logic             run_cmd,
    input  logic             step_cmd,
    input  logic             halt_cmd,
    output logic             enF,
    output logic             enD,
    output logic             enE,
    output logic             enM,
    output logic             enWB,
    output logic             clrD,
    output logic             clrE,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             rel_q;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] stl_q, stl_d;
    logic [CNT_W-1:0] fls_q, fls_d;
    logic             active, adv, hcyc;

    // rel_q masks commands during the first cycle after reset release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HALTED;
            rel_q   <= 1'b1;
            cyc_q   <= '0;
            stl_q   <= '0;
            fls_q   <= '0;
        end else begin
            state_q <= state_d;
            rel_q   <= 1'b0;
            cyc_q   <= cyc_d;
            stl_q   <= stl_d;
            fls_q   <= fls_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HALTED: begin
                if (!rel_q) begin
                    if (step_cmd)     state_d = STEP;
                    else if (run_cmd) state_d = RUN;
                end
            end
            RUN: begin
                if (halt_instr_wb) state_d = DONE;
                else if (halt_cmd) state_d = HALTED;
            end
            STEP: begin
                if (halt_instr_wb) state_d = DONE;
                else               state_d = HALTED;
            end
            DONE: state_d = DONE;
            default: state_d = HALTED;
        endcase
    end

    assign active = (state_q == RUN) || (state_q == STEP);
    assign adv    = active & ~halt_instr_wb;
    assign hcyc   = active & halt_instr_wb;

    always_comb begin
        enF  = 1'b0;
        enD  = 1'b0;
        enE  = 1'b0;
        enM  = 1'b0;
        enWB = 1'b0;
        clrD = 1'b0;
        clrE = 1'b0;
        if (adv) begin
            enWB = 1'b1;
            enM  = 1'b1;
            enE  = 1'b1;
            enF  = ~stall_req;
            enD  = ~stall_req;
            clrE = stall_req;
            clrD = branch_taken & ~stall_req;
        end else if (hcyc) begin
            enWB = 1'b1;
        end
    end

    always_comb begin
        cyc_d = cyc_q;
        stl_d = stl_q;
        fls_d = fls_q;
        if ((adv || hcyc) && (cyc_q != '1)) cyc_d = cyc_q + 1'b1;
        if (adv && stall_req && (stl_q != '1)) stl_d = stl_q + 1'b1;
        if (clrD && (fls_q != '1)) fls_d = fls_q + 1'b1;
    end

    assign running   = active;
    assign done      = (state_q == DONE);
    assign cycle_cnt = cyc_q;
    assign stall_cnt = stl_q;
    assign flush_cnt = fls_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl: a 32-bit counter instance and a
// 4-bit counter instance share one stimulus stream.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall_req = 1'b0, branch_taken = 1'b0, halt_instr_wb = 1'b0;
    logic run_cmd = 1'b0, step_cmd = 1'b0, halt_cmd = 1'b0;

    logic enF, enD, enE, enM, enWB, clrD, clrE, running, done;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
    logic enF4, enD4, enE4, enM4, enWB4, clrD4, clrE4, running4, done4;
    logic [3:0] cycle_cnt4, stall_cnt4, flush_cnt4;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall_req(stall_req),
        .branch_taken(branch_taken), .halt_instr_wb(halt_instr_wb),
        .run_cmd(run_cmd), .step_cmd(step_cmd), .halt_cmd(halt_cmd),
        .enF(enF), .enD(enD), .enE(enE), .enM(enM), .enWB(enWB),
        .clrD(clrD), .clrE(clrE), .running(running), .done(done),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall_req(stall_req),
        .branch_taken(branch_taken), .halt_instr_wb(halt_instr_wb),
        .run_cmd(run_cmd), .step_cmd(step_cmd), .halt_cmd(halt_cmd),
        .enF(enF4), .enD(enD4), .enE(enE4), .enM(enM4), .enWB(enWB4),
        .clrD(clrD4), .clrE(clrE4), .running(running4), .done(done4),
        .cycle_cnt(cycle_cnt4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    wire [6:0] ctl = {enF, enD, enE, enM, enWB, clrD, clrE};
    wire [1:0] st  = {running, done};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        repeat (5) tick();
        compared++;
        if (ctl !== 7'b0) begin
            mismatched++;
            $display("FAIL reset_ctl got=%b want=%b", ctl, 7'b0);
        end
        compared++;
        if (st !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_state got=%b want=00", st);
        end
        compared++;
        if ({cycle_cnt, stall_cnt, flush_cnt} !== 96'd0) begin
            mismatched++;
            $display("FAIL reset_cnt got=%0d/%0d/%0d want=0/0/0",
                     cycle_cnt, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_step();
        step_cmd = 1'b1;
        tick();
        step_cmd = 1'b0;
        #1;
        compared++;
        if ({ctl, st} !== 9'b1111100_10) begin
            mismatched++;
            $display("FAIL step_cycle got=%b want=%b", {ctl, st}, 9'b1111100_10);
        end
        tick();
        compared++;
        if ({ctl, st} !== 9'b0) begin
            mismatched++;
            $display("FAIL step_back got=%b want=%b", {ctl, st}, 9'b0);
        end
        compared++;
        if (cycle_cnt !== 32'd1) begin
            mismatched++;
            $display("FAIL step_cnt1 got=%0d want=1", cycle_cnt);
        end
        step_cmd = 1'b1;
        tick();
        step_cmd = 1'b0;
        tick();
        compared++;
        if (cycle_cnt !== 32'd2 || running !== 1'b0) begin
            mismatched++;
            $display("FAIL step_cnt2 got=%0d run=%b want=2 run=0", cycle_cnt, running);
        end
    endtask

    task automatic test_stall();
        run_cmd = 1'b1;
        tick();
        run_cmd = 1'b0;
        stall_req = 1'b1;
        #1;
        compared++;
        if (ctl !== 7'b0011101) begin
            mismatched++;
            $display("FAIL stall_c1 got=%b want=%b", ctl, 7'b0011101);
        end
        tick();
        compared++;
        if (ctl !== 7'b0011101) begin
            mismatched++;
            $display("FAIL stall_c2 got=%b want=%b", ctl, 7'b0011101);
        end
        tick();
        stall_req = 1'b0;
        #1;
        compared++;
        if (stall_cnt !== 32'd2) begin
            mismatched++;
            $display("FAIL stall_cnt got=%0d want=2", stall_cnt);
        end
        stall_req = 1'b1;
        branch_taken = 1'b1;
        #1;
        compared++;
        if (ctl !== 7'b0011101) begin
            mismatched++;
            $display("FAIL stall_br got=%b want=%b", ctl, 7'b0011101);
        end
        tick();
        stall_req = 1'b0;
        branch_taken = 1'b0;
        compared++;
        if (flush_cnt !== 32'd0 || stall_cnt !== 32'd3) begin
            mismatched++;
            $display("FAIL stall_br_cnt got=%0d/%0d want=0/3", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1;
        #1;
        compared++;
        if (ctl !== 7'b1111110) begin
            mismatched++;
            $display("FAIL branch_ctl got=%b want=%b", ctl, 7'b1111110);
        end
        tick();
        branch_taken = 1'b0;
        #1;
        compared++;
        if (ctl !== 7'b1111100) begin
            mismatched++;
            $display("FAIL branch_after got=%b want=%b", ctl, 7'b1111100);
        end
        compared++;
        if (flush_cnt !== 32'd1 || cycle_cnt !== 32'd6) begin
            mismatched++;
            $display("FAIL branch_cnt got=%0d/%0d want=1/6", flush_cnt, cycle_cnt);
        end
    endtask

    task automatic test_halt_instr();
        halt_instr_wb = 1'b1;
        stall_req = 1'b1;
        #1;
        compared++;
        if (ctl !== 7'b0000100) begin
            mismatched++;
            $display("FAIL halt_cyc got=%b want=%b", ctl, 7'b0000100);
        end
        tick();
        halt_instr_wb = 1'b0;
        stall_req = 1'b0;
        compared++;
        if ({ctl, st} !== 9'b0000000_01) begin
            mismatched++;
            $display("FAIL done_state got=%b want=%b", {ctl, st}, 9'b0000000_01);
        end
        compared++;
        if (cycle_cnt !== 32'd7 || stall_cnt !== 32'd3) begin
            mismatched++;
            $display("FAIL done_cnt got=%0d/%0d want=7/3", cycle_cnt, stall_cnt);
        end
        run_cmd = 1'b1;
        step_cmd = 1'b1;
        tick(); tick();
        run_cmd = 1'b0;
        step_cmd = 1'b0;
        compared++;
        if ({ctl, st} !== 9'b0000000_01 || cycle_cnt !== 32'd7) begin
            mismatched++;
            $display("FAIL done_sticky got=%b cnt=%0d want=%b cnt=7",
                     {ctl, st}, cycle_cnt, 9'b0000000_01);
        end
    endtask

    task automatic test_saturate();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_cmd = 1'b1;
        tick();
        compared++;
        if (running !== 1'b0) begin
            mismatched++;
            $display("FAIL release_cmd got=%b want=0", running);
        end
        tick();
        run_cmd = 1'b0;
        repeat (20) tick();
        halt_cmd = 1'b1;
        #1;
        compared++;
        if (ctl !== 7'b1111100) begin
            mismatched++;
            $display("FAIL haltcmd_adv got=%b want=%b", ctl, 7'b1111100);
        end
        tick();
        halt_cmd = 1'b0;
        compared++;
        if (running !== 1'b0 || cycle_cnt !== 32'd21) begin
            mismatched++;
            $display("FAIL haltcmd_cnt got=%b/%0d want=0/21", running, cycle_cnt);
        end
        compared++;
        if (cycle_cnt4 !== 4'd15) begin
            mismatched++;
            $display("FAIL sat_cnt got=%0d want=15", cycle_cnt4);
        end
    endtask

    task automatic test_async_reset();
        run_cmd = 1'b1;
        tick();
        run_cmd = 1'b0;
        tick();
        #1;
        reset = 1'b1;
        #1;
        compared++;
        if ({ctl, st} !== 9'b0) begin
            mismatched++;
            $display("FAIL async_ctl got=%b want=%b", {ctl, st}, 9'b0);
        end
        compared++;
        if ({cycle_cnt, stall_cnt, flush_cnt} !== 96'd0 || cycle_cnt4 !== 4'd0) begin
            mismatched++;
            $display("FAIL async_cnt got=%0d/%0d want=0/0", cycle_cnt, cycle_cnt4);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_step();
        test_stall();
        test_branch();
        test_halt_instr();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing block for the five-stage MIPS core. It consumes the stall, flush and branch-redirect requests raised by the hazard logic and turns them into per-stage register enables and clears. It also runs the core's execution-mode state machine (halted, run, single-step, done) for the debug interface, and keeps saturating cycle, stall and flush counters for the debug unit to read.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-high; forces the reset state immediately
- stall_req  in  1  load-use stall request from the hazard logic (stallF/stallD/flushE asserted together)
- branch_taken  in  1  control-transfer redirect resolved in decode; the fetched instruction must be squashed
- halt_instr_wb  in  1  a halt instruction is in the WB stage this cycle
- run_cmd  in  1  debug pulse: start continuous execution
- step_cmd  in  1  debug pulse: advance the pipeline exactly one cycle
- halt_cmd  in  1  debug pulse: stop continuous execution
- enF  out  1  PC register enable
- enD  out  1  IF/ID register enable
- enE  out  1  ID/EX register enable
- enM  out  1  EX/MEM register enable
- enWB  out  1  MEM/WB register enable and register-file write qualifier
- clrD  out  1  synchronous clear of IF/ID (bubble)
- clrE  out  1  synchronous clear of ID/EX (bubble)
- running  out  1  high in RUN or STEP
- done  out  1  high in DONE
- cycle_cnt  out  CNT_W  count of advancing cycles
- stall_cnt  out  CNT_W  count of advancing cycles with stall_req
- flush_cnt  out  CNT_W  count of advancing cycles with branch_taken applied

## Operation
- State register has four states: HALTED, RUN, STEP, DONE. Reset state is HALTED.
- HALTED transitions:
  - run_cmd -> RUN
  - step_cmd -> STEP
  - all other inputs are ignored (stay HALTED)
- RUN transitions:
  - halt_instr_wb -> DONE
  - halt_cmd -> HALTED
  - otherwise stay RUN
- STEP transitions:
  - halt_instr_wb -> DONE
  - otherwise -> HALTED unconditionally; STEP lasts exactly one cycle
- DONE is terminal. Only reset leaves it; all commands are ignored.
- Priority when events coincide: halt_instr_wb > halt_cmd > step_cmd > run_cmd. A command that is invalid for the current state is dropped, not queued.
- Advancing cycle: state is RUN or STEP and halt_instr_wb is 0. Enables and clears in an advancing cycle:
  - enWB = enM = enE = 1
  - enF = enD = ~stall_req
  - clrE = stall_req (bubble into EX)
  - clrD = branch_taken & ~stall_req
- When stall_req and branch_taken are high together, the stall wins. The redirect is re-presented by decode on the next cycle, so no flush is lost.
- Halt cycle: state is RUN or STEP and halt_instr_wb is 1. Then enWB = 1 and enF = enD = enE = enM = 0, clrD = clrE = 0, so the halt instruction retires and nothing behind it advances.
- In HALTED and DONE, every enable and clear is 0.
- Counters (all three saturate at 2^CNT_W-1; no wrap):
  - cycle_cnt: +1 per advancing or halt cycle
  - stall_cnt: +1 per advancing cycle with stall_req
  - flush_cnt: +1 per advancing cycle where clrD is 1
- Counters are cleared only by reset.

## Timing
- Enables and clears are combinational from the current state and the same-cycle request inputs. There are no registered outputs, so the hazard logic's requests take effect in the same cycle they are raised.
- running and done decode the state register only (glitch-free w.r.t. inputs).
- Command sampled at edge N: the new state and its enables are valid from edge N to edge N+1. A halt_cmd cycle in RUN is itself an advancing cycle.
- Counters update at the edge that closes the cycle being counted; the new value is visible the following cycle.
- Reset asserted at any time:
  - state goes to HALTED immediately, so all enables and clears drop to 0 without waiting for a clock edge
  - counters go to 0 and running/done go to 0
  - release is synchronous to the next edge; no command is honoured in the cycle reset deasserts

## Test plan
- Reset, then idle 5 cycles -> all enables 0, running=0, done=0, all counters 0.
- step_cmd pulse from HALTED -> exactly one cycle of enF..enWB=1, then HALTED; cycle_cnt=1; second step_cmd -> cycle_cnt=2.
- RUN with stall_req high for 2 cycles -> enF=enD=0, clrE=1 both cycles; stall_cnt=2; with branch_taken also high -> clrD=0, flush_cnt unchanged.
- RUN with branch_taken for 1 cycle, no stall -> clrD=1 that cycle; flush_cnt=1.
- RUN, halt_instr_wb pulse -> that cycle only enWB=1; then DONE with done=1; subsequent run_cmd/step_cmd ignored until reset.
- Force counter near max (CNT_W=4, run 20 cycles) -> cycle_cnt holds at 15. Separately, assert reset mid-RUN -> outputs 0 before the next edge.
